// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the ID-stage hazard detection / forwarding controller.
//   hz_state_e : controller state encoding (IDLE, LOAD_STALL, MEM_WAIT)
//   FWD_RF     : forward-select value meaning "take the register file value"
//   sel_w()    : width of a forward select for a given number of sources
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2
    } hz_state_e;

    // Select value 0 always means the register file; source i is encoded i+1.
    localparam int FWD_RF = 32'sd0;

    // Width needed to encode {register file, source 0 .. source num_fwd-1}.
    function automatic int sel_w(input int num_fwd);
        return $clog2(num_fwd + 32'sd1);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select
// Priority forwarding match for one ID-stage operand. The youngest producer
// (lowest index) whose destination matches the source register wins.
// Ports:
//   rs        in  REG_AW          source register of the operand
//   rs_used   in  1               instruction actually reads this operand
//   src_rd    in  NUM_FWD*REG_AW  destination register per producer stage
//   src_rf_we in  NUM_FWD         register write enable per producer stage
//   sel       out SEL_W           0 = register file, i+1 = producer i
// -----------------------------------------------------------------------------
module fwd_select
    import hazard_pkg::*;
#(
    parameter  int REG_AW  = 5,
    parameter  int NUM_FWD = 3,
    localparam int SEL_W   = sel_w(NUM_FWD)
) (
    input  logic [REG_AW-1:0]         rs,
    input  logic                      rs_used,
    input  logic [NUM_FWD*REG_AW-1:0] src_rd,
    input  logic [NUM_FWD-1:0]        src_rf_we,
    output logic [SEL_W-1:0]          sel
);

    // Priority match: scan oldest to youngest so the youngest match is left last.
    always_comb begin
        sel = SEL_W'(FWD_RF);
        if (rs_used && (rs != {REG_AW{1'b0}})) begin
            for (int i = NUM_FWD - 1; i >= 0; i--) begin
                sel = (src_rf_we[i] && (src_rd[i*REG_AW +: REG_AW] == rs))
                    ? SEL_W'(i + 32'sd1) : sel;
            end
        end else begin
            // x0 is hard-wired zero and unused operands never need a bypass.
            sel = SEL_W'(FWD_RF);
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl
// Hazard detection and operand forwarding controller beside the ID stage.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   id_rs1/id_rs2 (+ _used)     ID-stage source registers and use flags
//   src_rd, src_rf_we           destination / write enable per producer stage
//                               (index 0 = EX, 1 = MEM, 2 = WB, higher = older)
//   ex_is_load                  instruction in EX is a load
//   mem_req, dmem_ready         data memory access in MEM and its completion
//   branch_taken                redirect resolved this cycle
//   fwd_sel_a, fwd_sel_b        operand mux selects (0 = register file)
//   pc_en, if_id_en             register enables
//   id_ex_bubble, if_id_flush   NOP insertion into ID/EX, clear of IF/ID
//   pipe_freeze                 hold every pipeline register
//   stall_cycles, flush_count   saturating performance counters
// Control outputs are combinational from inputs and the current state so they
// act in the same cycle; the state, stall down-counter and counters are
// registered.
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter  int REG_AW   = 5,
    parameter  int NUM_FWD  = 3,
    parameter  int LOAD_LAT = 1,
    parameter  int CNT_W    = 32,
    localparam int SEL_W    = sel_w(NUM_FWD),
    localparam int LCNT_W   = $clog2(LOAD_LAT + 32'sd1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_AW-1:0]         id_rs1,
    input  logic [REG_AW-1:0]         id_rs2,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic [NUM_FWD*REG_AW-1:0] src_rd,
    input  logic [NUM_FWD-1:0]        src_rf_we,
    input  logic                      ex_is_load,
    input  logic                      mem_req,
    input  logic                      dmem_ready,
    input  logic                      branch_taken,
    output logic [SEL_W-1:0]          fwd_sel_a,
    output logic [SEL_W-1:0]          fwd_sel_b,
    output logic                      pc_en,
    output logic                      if_id_en,
    output logic                      id_ex_bubble,
    output logic                      if_id_flush,
    output logic                      pipe_freeze,
    output logic [CNT_W-1:0]          stall_cycles,
    output logic [CNT_W-1:0]          flush_count
);

    localparam logic [LCNT_W-1:0] LCNT_ZERO = {LCNT_W{1'b0}};
    localparam logic [LCNT_W-1:0] LCNT_ONE  = LCNT_W'(32'd1);
    localparam logic [LCNT_W-1:0] LCNT_INIT = LCNT_W'(LOAD_LAT - 32'sd1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(32'd1);

    hz_state_e           state_r;
    hz_state_e           state_nxt_s;
    logic [LCNT_W-1:0]   lcnt_r;
    logic [LCNT_W-1:0]   lcnt_nxt_s;
    logic [SEL_W-1:0]    sel_a_s;
    logic [SEL_W-1:0]    sel_b_s;
    logic [REG_AW-1:0]   ex_rd_s;
    logic                load_hz_s;
    logic                freeze_s;
    logic                flush_s;
    logic                ld_stall_s;

    fwd_select #(
        .REG_AW  (REG_AW),
        .NUM_FWD (NUM_FWD)
    ) u_fwd_a (
        .rs        (id_rs1),
        .rs_used   (id_rs1_used),
        .src_rd    (src_rd),
        .src_rf_we (src_rf_we),
        .sel       (sel_a_s)
    );

    fwd_select #(
        .REG_AW  (REG_AW),
        .NUM_FWD (NUM_FWD)
    ) u_fwd_b (
        .rs        (id_rs2),
        .rs_used   (id_rs2_used),
        .src_rd    (src_rd),
        .src_rf_we (src_rf_we),
        .sel       (sel_b_s)
    );

    // Hazard conditions and the priority-resolved control class of this cycle.
    always_comb begin
        ex_rd_s   = src_rd[REG_AW-1:0];
        load_hz_s = ex_is_load && src_rf_we[0] && (ex_rd_s != {REG_AW{1'b0}}) &&
                    ((id_rs1_used && (id_rs1 == ex_rd_s)) ||
                     (id_rs2_used && (id_rs2 == ex_rd_s)));
        freeze_s  = mem_req && !dmem_ready;
        // A freeze outranks a flush, and a flush outranks any load stall.
        flush_s   = branch_taken && !freeze_s;
        ld_stall_s = !freeze_s && !branch_taken &&
                     (((state_r == ST_IDLE) && load_hz_s) || (state_r == ST_LOAD_STALL));
    end

    // Output drive; reset forces a benign "run" pattern on every control.
    always_comb begin
        fwd_sel_a    = SEL_W'(FWD_RF);
        fwd_sel_b    = SEL_W'(FWD_RF);
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        pipe_freeze  = 1'b0;
        if (rst) begin
            fwd_sel_a = SEL_W'(FWD_RF);
            fwd_sel_b = SEL_W'(FWD_RF);
        end else begin
            fwd_sel_a = sel_a_s;
            fwd_sel_b = sel_b_s;
            if (freeze_s) begin
                pipe_freeze = 1'b1;
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
            end else if (flush_s) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (ld_stall_s) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
            end else begin
                pc_en = 1'b1;
            end
        end
    end

    // Next-state logic for the stall / memory-wait controller.
    always_comb begin
        state_nxt_s = state_r;
        lcnt_nxt_s  = lcnt_r;
        case (state_r)
            ST_IDLE: begin
                if (freeze_s) begin
                    state_nxt_s = ST_MEM_WAIT;
                end else if (branch_taken) begin
                    // Flush kills the consumer in ID, so no stall is armed.
                    state_nxt_s = ST_IDLE;
                end else if (load_hz_s && (LOAD_LAT > 32'sd1)) begin
                    // The detect cycle is the first bubble; LOAD_LAT-1 remain.
                    state_nxt_s = ST_LOAD_STALL;
                    lcnt_nxt_s  = LCNT_INIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD_STALL: begin
                if (freeze_s) begin
                    // Frozen cycles do not consume stall budget.
                    state_nxt_s = ST_MEM_WAIT;
                end else if (branch_taken) begin
                    state_nxt_s = ST_IDLE;
                    lcnt_nxt_s  = LCNT_ZERO;
                end else begin
                    lcnt_nxt_s  = lcnt_r - LCNT_ONE;
                    state_nxt_s = (lcnt_r == LCNT_ONE) ? ST_IDLE : ST_LOAD_STALL;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    state_nxt_s = (lcnt_r != LCNT_ZERO) ? ST_LOAD_STALL : ST_IDLE;
                end else begin
                    state_nxt_s = ST_MEM_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                lcnt_nxt_s  = LCNT_ZERO;
            end
        endcase
    end

    // State and stall down-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            lcnt_r  <= LCNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            lcnt_r  <= lcnt_nxt_s;
        end
    end

    // Saturating performance counters: stalled-PC cycles and flush cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= CNT_ZERO;
            flush_count  <= CNT_ZERO;
        end else begin
            if (!pc_en && !(&stall_cycles)) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end else begin
                stall_cycles <= stall_cycles;
            end
            if (flush_s && !(&flush_count)) begin
                flush_count <= flush_count + CNT_ONE;
            end else begin
                flush_count <= flush_count;
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
// Directed vectors with hand-computed expectations. Each vector is driven just
// after a rising edge and its expected response pushed to a queue; a monitor
// pops and compares on the following falling edge.
// Control word order: {pc_en, if_id_en, id_ex_bubble, if_id_flush, pipe_freeze}
// -----------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;

    localparam int REG_AW   = 5;
    localparam int NUM_FWD  = 3;
    localparam int LOAD_LAT = 3;
    localparam int CNT_W    = 4;

    localparam logic [4:0] C_N = 5'b11000; // normal
    localparam logic [4:0] C_S = 5'b00100; // load stall
    localparam logic [4:0] C_F = 5'b11110; // flush
    localparam logic [4:0] C_Z = 5'b00001; // freeze

    logic                      clk;
    logic                      rst;
    logic [REG_AW-1:0]         id_rs1, id_rs2;
    logic                      id_rs1_used, id_rs2_used;
    logic [NUM_FWD*REG_AW-1:0] src_rd;
    logic [NUM_FWD-1:0]        src_rf_we;
    logic                      ex_is_load, mem_req, dmem_ready, branch_taken;
    logic [1:0]                fwd_sel_a, fwd_sel_b;
    logic                      pc_en, if_id_en, id_ex_bubble, if_id_flush, pipe_freeze;
    logic [CNT_W-1:0]          stall_cycles, flush_count;

    typedef struct {
        string      nm;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [4:0] ctl;
        logic [3:0] sc;
        logic [3:0] fc;
        bit         chk_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests;
    int   n_fail;

    hazard_fwd_ctrl #(
        .REG_AW   (REG_AW),
        .NUM_FWD  (NUM_FWD),
        .LOAD_LAT (LOAD_LAT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .src_rd       (src_rd),
        .src_rf_we    (src_rf_we),
        .ex_is_load   (ex_is_load),
        .mem_req      (mem_req),
        .dmem_ready   (dmem_ready),
        .branch_taken (branch_taken),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_bubble (id_ex_bubble),
        .if_id_flush  (if_id_flush),
        .pipe_freeze  (pipe_freeze),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected entry per driven cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [4:0] act_ctl;
            e = exp_q.pop_front();
            act_ctl = {pc_en, if_id_en, id_ex_bubble, if_id_flush, pipe_freeze};
            n_tests++;
            if ((fwd_sel_a !== e.sa) || (fwd_sel_b !== e.sb) || (act_ctl !== e.ctl) ||
                (e.chk_cnt && ((stall_cycles !== e.sc) || (flush_count !== e.fc)))) begin
                n_fail++;
                $display("FAIL %s: got sel_a=%0d sel_b=%0d ctl=%b stall=%0d flush=%0d, want sel_a=%0d sel_b=%0d ctl=%b stall=%0d flush=%0d (cnt checked=%0d)",
                         e.nm, fwd_sel_a, fwd_sel_b, act_ctl, stall_cycles, flush_count,
                         e.sa, e.sb, e.ctl, e.sc, e.fc, e.chk_cnt);
            end
        end
    end

    // Drive one cycle of inputs and queue its expected response.
    task automatic v(input string nm, input logic r,
                     input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2,
                     input logic [14:0] rd, input logic [2:0] we,
                     input logic ld, input logic mreq, input logic drdy, input logic br,
                     input logic [1:0] sa, input logic [1:0] sb, input logic [4:0] ctl,
                     input int sc, input int fc, input bit chk);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        id_rs1       = rs1;
        id_rs1_used  = u1;
        id_rs2       = rs2;
        id_rs2_used  = u2;
        src_rd       = rd;
        src_rf_we    = we;
        ex_is_load   = ld;
        mem_req      = mreq;
        dmem_ready   = drdy;
        branch_taken = br;
        e.nm = nm; e.sa = sa; e.sb = sb; e.ctl = ctl;
        e.sc = 4'(sc); e.fc = 4'(fc); e.chk_cnt = chk;
        exp_q.push_back(e);
    endtask

    localparam logic [14:0] R555 = {5'd5, 5'd5, 5'd5};
    localparam logic [14:0] R_EX7  = {5'd0, 5'd0, 5'd7};
    localparam logic [14:0] R_MEM7 = {5'd0, 5'd7, 5'd0};
    localparam logic [14:0] R_WB7  = {5'd7, 5'd0, 5'd0};

    initial begin
        n_tests = 0;
        n_fail  = 0;
        //   name           rst rs1  u  rs2  u  rd                  we     ld mr dr br  sa sb ctl  sc fc chk
        v("rst_hold",       1, 5'd5,1, 5'd0,0, R555,               3'b111,0, 0, 1, 0,  0, 0, C_N, 0, 0, 0);
        v("rst_cnt",        1, 5'd5,1, 5'd0,0, R555,               3'b111,0, 0, 1, 0,  0, 0, C_N, 0, 0, 1);
        v("fwd_ex",         0, 5'd5,1, 5'd0,0, R555,               3'b111,0, 0, 1, 0,  1, 0, C_N, 0, 0, 1);
        v("fwd_mem",        0, 5'd5,1, 5'd0,0, R555,               3'b110,0, 0, 1, 0,  2, 0, C_N, 0, 0, 1);
        v("fwd_x0",         0, 5'd0,1, 5'd0,1, 15'd0,              3'b111,0, 0, 1, 0,  0, 0, C_N, 0, 0, 1);
        v("fwd_wb_a_mem_b", 0, 5'd5,1, 5'd4,1, {5'd5,5'd4,5'd3},   3'b111,0, 0, 1, 0,  3, 2, C_N, 0, 0, 1);
        v("unused_b",       0, 5'd9,1, 5'd9,0, {5'd0,5'd0,5'd9},   3'b001,0, 0, 1, 0,  1, 0, C_N, 0, 0, 1);
        v("load_unused",    0, 5'd0,0, 5'd9,0, {5'd0,5'd0,5'd9},   3'b001,1, 0, 1, 0,  0, 0, C_N, 0, 0, 1);
        // Load-use, LOAD_LAT=3: three consecutive stall cycles.
        v("ld_stall1",      0, 5'd7,1, 5'd0,0, R_EX7,              3'b001,1, 0, 1, 0,  1, 0, C_S, 0, 0, 1);
        v("ld_stall2",      0, 5'd7,1, 5'd0,0, R_MEM7,             3'b010,0, 0, 1, 0,  2, 0, C_S, 1, 0, 1);
        v("ld_stall3",      0, 5'd7,1, 5'd0,0, R_WB7,              3'b100,0, 0, 1, 0,  3, 0, C_S, 2, 0, 1);
        v("ld_done",        0, 5'd7,1, 5'd0,0, 15'd0,              3'b000,0, 0, 1, 0,  0, 0, C_N, 3, 0, 1);
        // Memory wait in the second stall cycle: two frozen cycles, lcnt kept.
        v("fz_stall1",      0, 5'd7,1, 5'd0,0, R_EX7,              3'b001,1, 0, 1, 0,  1, 0, C_S, 3, 0, 1);
        v("fz_freeze1",     0, 5'd7,1, 5'd0,0, R_MEM7,             3'b010,0, 1, 0, 0,  2, 0, C_Z, 4, 0, 1);
        v("fz_freeze2",     0, 5'd7,1, 5'd0,0, R_MEM7,             3'b010,0, 1, 0, 0,  2, 0, C_Z, 5, 0, 1);
        v("fz_exit",        0, 5'd7,1, 5'd0,0, R_MEM7,             3'b010,0, 1, 1, 0,  2, 0, C_N, 6, 0, 1);
        v("fz_stall2",      0, 5'd7,1, 5'd0,0, R_MEM7,             3'b010,0, 0, 1, 0,  2, 0, C_S, 6, 0, 1);
        v("fz_stall3",      0, 5'd7,1, 5'd0,0, R_MEM7,             3'b010,0, 0, 1, 0,  2, 0, C_S, 7, 0, 1);
        v("fz_done",        0, 5'd7,1, 5'd0,0, R_MEM7,             3'b010,0, 0, 1, 0,  2, 0, C_N, 8, 0, 1);
        // Branch together with a load hazard: flush wins, no stall.
        v("br_with_ld",     0, 5'd7,1, 5'd0,0, R_EX7,              3'b001,1, 0, 1, 1,  1, 0, C_F, 8, 0, 1);
        v("br_after",       0, 5'd0,0, 5'd0,0, 15'd0,              3'b000,0, 0, 1, 0,  0, 0, C_N, 8, 1, 1);
        // Branch inside a load stall abandons it.
        v("br_ls1",         0, 5'd7,1, 5'd0,0, R_EX7,              3'b001,1, 0, 1, 0,  1, 0, C_S, 8, 1, 1);
        v("br_ls2",         0, 5'd7,1, 5'd0,0, R_MEM7,             3'b010,0, 0, 1, 1,  2, 0, C_F, 9, 1, 1);
        v("br_ls_done",     0, 5'd0,0, 5'd0,0, 15'd0,              3'b000,0, 0, 1, 0,  0, 0, C_N, 9, 2, 1);
        // Freeze from IDLE returns to IDLE.
        v("fz_idle",        0, 5'd0,0, 5'd0,0, 15'd0,              3'b000,0, 1, 0, 0,  0, 0, C_Z, 9, 2, 1);
        v("fz_idle_exit",   0, 5'd0,0, 5'd0,0, 15'd0,              3'b000,0, 1, 1, 0,  0, 0, C_N,10, 2, 1);
        v("idle_again",     0, 5'd0,0, 5'd0,0, 15'd0,              3'b000,0, 0, 1, 0,  0, 0, C_N,10, 2, 1);
        // Reset during LOAD_STALL aborts it and clears counters.
        v("rst_ls1",        0, 5'd7,1, 5'd0,0, R_EX7,              3'b001,1, 0, 1, 0,  1, 0, C_S,10, 2, 1);
        v("rst_ls2",        1, 5'd7,1, 5'd0,0, R_MEM7,             3'b010,0, 0, 1, 0,  0, 0, C_N,11, 2, 1);
        v("rst_after",      0, 5'd7,1, 5'd0,0, R_WB7,              3'b100,0, 0, 1, 0,  3, 0, C_N, 0, 0, 1);
        // Saturation of the 4-bit stall counter under a long freeze.
        for (int j = 0; j < 18; j++) begin
            v("sat_stall",  0, 5'd0,0, 5'd0,0, 15'd0,              3'b000,0, 1, 0, 0,  0, 0, C_Z, (j > 15) ? 15 : j, 0, 1);
        end
        v("sat_fz_exit",    0, 5'd0,0, 5'd0,0, 15'd0,              3'b000,0, 1, 1, 0,  0, 0, C_N,15, 0, 1);
        // Saturation of the flush counter.
        for (int k = 0; k < 17; k++) begin
            v("sat_flush",  0, 5'd0,0, 5'd0,0, 15'd0,              3'b000,0, 0, 1, 1,  0, 0, C_F,15, (k > 15) ? 15 : k, 1);
        end
        v("sat_done",       0, 5'd0,0, 5'd0,0, 15'd0,              3'b000,0, 0, 1, 0,  0, 0, C_N,15,15, 1);

        // Let the monitor drain, with a bounded wait.
        for (int w = 0; w < 10; w++) begin
            if (exp_q.size() > 0) begin
                @(negedge clk);
                #1;
            end
        end
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
